ex_stage_pipe: RTL and testbench

Registered, handshaked execute stage for the MIPS datapath: selects operands (register/PC, register/immediate), performs the ALU operation and presents the result through a one-entry output register with valid/ready flow control. Sits between the decode/register-read stage and the data-memory stage. Generalises the single-cycle execute path to a parametrised data width, adds backpressure, shift operations and an optional iterative unsigned multiplier that stalls the stage for a fixed number of cycles.

---
 rtl/ex_stage_pipe_pkg.sv | 29 ++
 rtl/ex_stage_pipe_if.sv | 34 +++
 rtl/ex_stage_pipe_mul_iter.sv | 47 ++++
 rtl/ex_stage_pipe.sv | 148 ++++++++++++++
 tb/tb_ex_stage_pipe.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_stage_pipe_pkg.sv
// Shared definitions for the execute stage: ALU operation codes, FSM states
// and the shift-amount width helper.
// Optional feature macro used by the stage: EX_MULDIV_EN (iterative multiplier).
package ex_pkg;

    localparam logic [3:0] ALU_AND    = 4'b0000;
    localparam logic [3:0] ALU_OR     = 4'b0001;
    localparam logic [3:0] ALU_ADD    = 4'b0010;
    localparam logic [3:0] ALU_SLL    = 4'b0011;
    localparam logic [3:0] ALU_SRL    = 4'b0100;
    localparam logic [3:0] ALU_SUB    = 4'b0110;
    localparam logic [3:0] ALU_SLT    = 4'b0111;
    localparam logic [3:0] ALU_MUL_LO = 4'b1000;
    localparam logic [3:0] ALU_MUL_HI = 4'b1001;
    localparam logic [3:0] ALU_NOR    = 4'b1100;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } ex_state_e;

    // The shamt field is imm[10:6], so at most 5 bits; narrower datapaths use fewer.
    function automatic int shamt_w(input int w);
        int lg;
        lg = $clog2(w);
        return (lg < 5) ? lg : 5;
    endfunction

endpackage

// File: rtl/ex_stage_pipe_if.sv
// Handshake and operand bundle between decode, execute and memory stages.
// master: upstream/downstream environment; slave: the execute stage itself.
interface ex_stage_pipe_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] pc_next_in;
    logic [DATA_W-1:0] rd1_in;
    logic [DATA_W-1:0] rd2_in;
    logic [DATA_W-1:0] imm_in;
    logic              rd1_sel_in;
    logic              rd2_sel_in;
    logic [CTRL_W-1:0] alu_ctrl_in;
    logic              mem_en_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] alu_result;
    logic              mem_en_out;
    logic              busy;

    modport master (
        output in_valid, pc_next_in, rd1_in, rd2_in, imm_in,
               rd1_sel_in, rd2_sel_in, alu_ctrl_in, mem_en_in, out_ready,
        input  in_ready, out_valid, alu_result, mem_en_out, busy
    );

    modport slave (
        input  in_valid, pc_next_in, rd1_in, rd2_in, imm_in,
               rd1_sel_in, rd2_sel_in, alu_ctrl_in, mem_en_in, out_ready,
        output in_ready, out_valid, alu_result, mem_en_out, busy
    );
endinterface

// File: rtl/ex_stage_pipe_mul_iter.sv
// Iterative unsigned shift-add multiplier, one partial product per step.
// Only instantiated when EX_MULDIV_EN is defined. The product port shows the
// accumulator including the current step, so on the done cycle it already
// holds the final 2*DATA_W-bit result.
module mul_iter #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  step_en,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);
    localparam int CW = $clog2(DATA_W);

    logic [2*DATA_W-1:0] mcand;
    logic [2*DATA_W-1:0] acc;
    logic [DATA_W-1:0]   mplier;
    logic [CW-1:0]       count;

    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = step_en && (count == CW'(DATA_W - 1));

    // Latch operands on start, then add/shift once per step until the counter wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (start) begin
            mcand  <= {{DATA_W{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            count  <= '0;
        end else if (step_en) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= done ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/ex_stage_pipe.sv
// Registered execute stage: operand select, ALU, one-entry output register
// with valid/ready flow control. Define EX_MULDIV_EN to add the iterative
// unsigned multiplier (MUL_LO/MUL_HI), which stalls the stage while running.
module ex_stage_pipe
    import ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    ex_stage_pipe_if.slave  bus
);
    localparam int SHW = shamt_w(DATA_W);

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [SHW-1:0]    shamt;
    logic [DATA_W-1:0] alu_val;
    logic [DATA_W-1:0] result_q;
    logic              out_valid_q;
    logic              mem_en_q;
    logic              in_ready;
    logic              accept;
    logic              busy;
    logic              load;
    logic [DATA_W-1:0] load_val;
    logic              load_mem;

    assign in_ready       = !busy && (!out_valid_q || bus.out_ready);
    assign accept         = bus.in_valid && in_ready;
    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.alu_result = result_q;
    assign bus.mem_en_out = mem_en_q;
    assign bus.busy       = busy;

    // Operand muxing and the single-cycle ALU; multiply codes fall to zero here.
    always_comb begin
        op_a    = bus.rd1_sel_in ? bus.pc_next_in : bus.rd1_in;
        op_b    = bus.rd2_sel_in ? bus.imm_in : bus.rd2_in;
        shamt   = bus.imm_in[6 +: SHW];
        alu_val = '0;
        case (bus.alu_ctrl_in)
            ALU_AND: alu_val = op_a & op_b;
            ALU_OR:  alu_val = op_a | op_b;
            ALU_ADD: alu_val = op_a + op_b;
            ALU_SLL: alu_val = op_a << shamt;
            ALU_SRL: alu_val = op_a >> shamt;
            ALU_SUB: alu_val = op_a - op_b;
            ALU_SLT: alu_val = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_NOR: alu_val = ~(op_a | op_b);
            default: alu_val = '0;
        endcase
    end

`ifdef EX_MULDIV_EN
    ex_state_e           state;
    ex_state_e           next_state;
    logic                is_mul;
    logic                mul_start;
    logic                mul_done;
    logic                hi_q;
    logic                mem_en_mul_q;
    logic [2*DATA_W-1:0] product;
    logic [DATA_W-1:0]   mul_sel;

    assign is_mul    = (bus.alu_ctrl_in == ALU_MUL_LO) || (bus.alu_ctrl_in == ALU_MUL_HI);
    assign mul_start = accept && is_mul;
    assign mul_sel   = hi_q ? product[2*DATA_W-1:DATA_W] : product[DATA_W-1:0];

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Enter MUL on an accepted multiply, return once the last step completes.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (mul_start) next_state = ST_MUL;
            ST_MUL:  if (mul_done)  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // FSM outputs: the stage is busy for every multiply step.
    always_comb begin
        busy = (state == ST_MUL);
    end

    // Remember which half to return and the memory enable, since inputs are ignored in MUL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q         <= 1'b0;
            mem_en_mul_q <= 1'b0;
        end else if (mul_start) begin
            hi_q         <= (bus.alu_ctrl_in == ALU_MUL_HI);
            mem_en_mul_q <= bus.mem_en_in;
        end
    end

    mul_iter #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .step_en (busy),
        .a       (op_a),
        .b       (op_b),
        .done    (mul_done),
        .product (product)
    );

    // Output register source: single-cycle ALU on accept, or the finished product.
    always_comb begin
        load     = (accept && !is_mul) || mul_done;
        load_val = mul_done ? mul_sel : alu_val;
        load_mem = mul_done ? mem_en_mul_q : bus.mem_en_in;
    end
`else
    // Without the multiplier every accepted operation completes in one cycle.
    always_comb begin
        busy     = 1'b0;
        load     = accept;
        load_val = alu_val;
        load_mem = bus.mem_en_in;
    end
`endif

    // One-entry output register: load a new result, otherwise drain when consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            mem_en_q    <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            result_q    <= load_val;
            mem_en_q    <= load_mem;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Self-checking bench for ex_stage_pipe (DATA_W=32). Directed scenarios plus a
// randomized run against a behavioural model and an in-order scoreboard.
// Multiply expectations depend on whether EX_MULDIV_EN is defined.
module tb_ex_stage_pipe;

    localparam int W = 32;
`ifdef EX_MULDIV_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    ex_stage_pipe_if #(.DATA_W(W), .CTRL_W(4)) bus ();

    ex_stage_pipe #(.DATA_W(W), .CTRL_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: what the operation means, computed with plain arithmetic.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] imm);
        logic [63:0] prod;
        int          sa;
        int          sb;
        int unsigned sh;
        prod = 64'(a) * 64'(b);
        sa   = a;
        sb   = b;
        sh   = imm[10:6];
        case (op)
            4'h0: return a & b;
            4'h1: return a | b;
            4'h2: return a + b;
            4'h3: return a << sh;
            4'h4: return a >> sh;
            4'h6: return a - b;
            4'h7: return (sa < sb) ? 32'd1 : 32'd0;
            4'hC: return ~(a | b);
            4'h8: return MUL_EN ? prod[31:0] : 32'd0;
            4'h9: return MUL_EN ? prod[63:32] : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic s1, input logic s2,
                          input logic [31:0] pc, input logic me);
        bus.in_valid    = 1'b1;
        bus.alu_ctrl_in = op;
        bus.rd1_in      = a;
        bus.rd2_in      = b;
        bus.imm_in      = imm;
        bus.rd1_sel_in  = s1;
        bus.rd2_sel_in  = s2;
        bus.pc_next_in  = pc;
        bus.mem_en_in   = me;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        set_op(4'h0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks += 5;
        if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        if (bus.alu_result !== 32'h0) begin failures++; $display("[TB] FAIL reset_result: got %h expected 0", bus.alu_result); end
        if (bus.mem_en_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_en: got %b expected 0", bus.mem_en_out); end
        if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ops [3] = '{4'h2, 4'h6, 4'h7};
        logic [31:0] as  [3] = '{32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF};
        logic [31:0] exp [3] = '{32'h0, 32'hFFFF_FFFF, 32'h1};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_op(ops[i], as[i], 32'h1, 32'h0, 1'b0, 1'b0, 32'h0, i[0]);
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_in_ready[%0d]: got %b expected 1", i, bus.in_ready); end
            tick();
            checks += 3;
            if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL b2b_valid[%0d]: got %b expected 1", i, bus.out_valid); end
            if (bus.alu_result !== exp[i]) begin failures++; $display("[TB] FAIL b2b_result[%0d]: got %h expected %h", i, bus.alu_result, exp[i]); end
            if (bus.mem_en_out !== i[0]) begin failures++; $display("[TB] FAIL b2b_mem_en[%0d]: got %b expected %b", i, bus.mem_en_out, i[0]); end
        end
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL b2b_drain: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_operand_select();
        bus.out_ready = 1'b1;
        set_op(4'h2, 32'h1234_5678, 32'hDEAD_BEEF, 32'h10, 1'b1, 1'b1, 32'h0040_0004, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.alu_result !== 32'h0040_0014) begin failures++; $display("[TB] FAIL opsel_result: got %h expected 00400014", bus.alu_result); end
        tick();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        set_op(4'h1, 32'hF0, 32'h0F, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        set_op(4'h2, 32'h1, 32'h2, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks += 3;
            if (bus.alu_result !== 32'hFF) begin failures++; $display("[TB] FAIL bp_hold[%0d]: got %h expected 000000ff", i, bus.alu_result); end
            if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_valid[%0d]: got %b expected 1", i, bus.out_valid); end
            if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
            tick();
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL bp_release: got %b expected 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        checks += 2;
        if (bus.alu_result !== 32'h3) begin failures++; $display("[TB] FAIL bp_second: got %h expected 00000003", bus.alu_result); end
        if (bus.mem_en_out !== 1'b1) begin failures++; $display("[TB] FAIL bp_second_mem: got %b expected 1", bus.mem_en_out); end
        tick();
    endtask

    task automatic test_multiply();
        logic [3:0]  ops [2] = '{4'h9, 4'h8};
        logic [31:0] exp [2];
        int          busy_cycles;
        exp[0] = MUL_EN ? 32'hFFFF_FFFE : 32'h0;
        exp[1] = MUL_EN ? 32'h0000_0001 : 32'h0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            set_op(ops[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
            tick();
            bus.in_valid = 1'b0;
            busy_cycles = 0;
            while (bus.busy === 1'b1 && busy_cycles < 200) begin
                if (busy_cycles == 1) begin
                    checks++;
                    if (bus.in_ready !== 1'b0) begin failures++; $display("[TB] FAIL mul_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
                end
                busy_cycles++;
                tick();
            end
            checks += 4;
            if (busy_cycles != (MUL_EN ? W : 0)) begin failures++; $display("[TB] FAIL mul_busy_cycles[%0d]: got %0d expected %0d", i, busy_cycles, MUL_EN ? W : 0); end
            if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL mul_valid[%0d]: got %b expected 1", i, bus.out_valid); end
            if (bus.alu_result !== exp[i]) begin failures++; $display("[TB] FAIL mul_result[%0d]: got %h expected %h", i, bus.alu_result, exp[i]); end
            if (bus.mem_en_out !== 1'b1) begin failures++; $display("[TB] FAIL mul_mem_en[%0d]: got %b expected 1", i, bus.mem_en_out); end
            tick();
        end
    endtask

    task automatic test_shifts();
        logic [3:0]  ops [3] = '{4'h3, 4'h4, 4'hF};
        logic [31:0] as  [3] = '{32'h1, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] exp [3] = '{32'h8000_0000, 32'h1, 32'h0};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_op(ops[i], as[i], 32'hFFFF_FFFF, 32'd31 << 6, 1'b0, 1'b0, 32'h0, 1'b0);
            tick();
            checks++;
            if (bus.alu_result !== exp[i]) begin failures++; $display("[TB] FAIL shift_result[%0d]: got %h expected %h", i, bus.alu_result, exp[i]); end
        end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_mul();
        bus.out_ready = 1'b1;
        set_op(4'h8, 32'h3, 32'h5, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        repeat (4) tick();
        #2 rst = 1'b1;
        #1;
        checks += 2;
        if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rstmul_valid: got %b expected 0", bus.out_valid); end
        if (bus.busy !== 1'b0) begin failures++; $display("[TB] FAIL rstmul_busy: got %b expected 0", bus.busy); end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("[TB] FAIL rstmul_in_ready: got %b expected 1", bus.in_ready); end
        set_op(4'h2, 32'h3, 32'h4, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        bus.in_valid = 1'b0;
        checks += 2;
        if (bus.out_valid !== 1'b1) begin failures++; $display("[TB] FAIL rstmul_add_valid: got %b expected 1", bus.out_valid); end
        if (bus.alu_result !== 32'h7) begin failures++; $display("[TB] FAIL rstmul_add: got %h expected 00000007", bus.alu_result); end
        repeat (W + 4) tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rstmul_no_ghost: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_random();
        logic [3:0]  pool [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6, 4'h7, 4'hC, 4'h8, 4'h9, 4'h5, 4'hF};
        logic [32:0] exp_q [$];
        logic [32:0] head;
        logic [3:0]  op;
        logic [31:0] a, b, imm, pc;
        logic        s1, s2, me, pending;
        int          guard;
        pending = 1'b0;
        bus.in_valid = 1'b0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (!pending && $urandom_range(0, 3) != 0) begin
                op  = pool[$urandom_range(0, 11)];
                a   = $urandom;
                b   = ($urandom_range(0, 3) == 0) ? 32'(int'($urandom_range(0, 8)) - 4) : $urandom;
                imm = $urandom;
                pc  = $urandom;
                s1  = 1'($urandom_range(0, 1));
                s2  = 1'($urandom_range(0, 1));
                me  = 1'($urandom_range(0, 1));
                set_op(op, a, b, imm, s1, s2, pc, me);
                pending = 1'b1;
            end else if (!pending) begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL rand_unexpected: got %h expected no result", bus.alu_result);
                end else begin
                    head = exp_q.pop_front();
                    if ({bus.mem_en_out, bus.alu_result} !== head) begin
                        failures++;
                        $display("[TB] FAIL rand_result: got %h expected %h", {bus.mem_en_out, bus.alu_result}, head);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready === 1'b1) begin
                exp_q.push_back({me, model(op, s1 ? pc : a, s2 ? imm : b, imm)});
                pending = 1'b0;
                checks++;
                if (exp_q.size() > 1) begin failures++; $display("[TB] FAIL rand_overwrite: got %0d outstanding expected 1", exp_q.size()); end
            end
            tick();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() > 0 && guard < 100) begin
            #1;
            if (bus.out_valid === 1'b1) begin
                checks++;
                head = exp_q.pop_front();
                if ({bus.mem_en_out, bus.alu_result} !== head) begin
                    failures++;
                    $display("[TB] FAIL rand_drain: got %h expected %h", {bus.mem_en_out, bus.alu_result}, head);
                end
            end
            guard++;
            tick();
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("[TB] FAIL rand_lost: got %0d pending expected 0", exp_q.size()); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        $display("[TB] start, multiplier %s", MUL_EN ? "enabled" : "disabled");
        test_reset();
        test_back_to_back();
        test_operand_select();
        test_backpressure();
        test_multiply();
        test_shifts();
        test_reset_mid_mul();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
